// File: rtl/hr_pkg.sv
// -----------------------------------------------------------------------------
// hr_pkg
// Shared constants, thresholds and types for the heart-rate chain (the RR
// interval detector upstream and rr_analyzer downstream). Both sides use
// these values so that they classify beats the same way.
//
//   RR_W / BPM_W      : data widths of an RR interval (ms) and a BPM value
//   MS_PER_MIN        : divider dividend, 60000 ms per minute
//   RR_SAT            : RR code the detector emits on saturation/timeout
//   *_DEF             : default classification thresholds
//   rr_state_t        : rr_analyzer control states
// -----------------------------------------------------------------------------
package hr_pkg;

    localparam int RR_W  = 12;
    localparam int BPM_W = 8;

    localparam logic [15:0]     MS_PER_MIN = 16'd60000;
    localparam logic [RR_W-1:0] RR_SAT     = 12'hFFF;

    // RR below this is an artefact (>240 BPM).
    localparam int MIN_RR_MS_DEF   = 250;
    // Average above this is bradycardia (<50 BPM).
    localparam int BRADY_MS_DEF    = 1200;
    // Average below this is tachycardia (>120 BPM).
    localparam int TACHY_MS_DEF    = 500;
    // Beat is irregular when it deviates from the average by more than
    // average >> IRREG_SHIFT_DEF (12.5 % for a shift of 3).
    localparam int IRREG_SHIFT_DEF = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        LOAD   = 3'd2,
        DIVIDE = 3'd3,
        UPDATE = 3'd4
    } rr_state_t;

    // Saturate a 16-bit quotient into the 8-bit BPM range.
    function automatic logic [BPM_W-1:0] clamp_bpm(input logic [15:0] q);
        return (q > 16'd255) ? 8'hFF : q[BPM_W-1:0];
    endfunction

    // Magnitude of the difference of two RR values.
    function automatic logic [RR_W-1:0] abs_diff(input logic [RR_W-1:0] a,
                                                 input logic [RR_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider, one quotient bit per clock, fixed N-cycle
// latency after start.
//
//   clk_div   in   clock
//   rst_n     in   asynchronous active-low reset
//   start     in   load dividend/divisor; iterations run on the next N edges
//   dividend  in   N-bit dividend
//   divisor   in   D_W-bit divisor (0 yields an all-ones quotient)
//   done      out  high in the cycle whose closing edge performs the final
//                  iteration, so the owner can step its FSM on that edge
//   quotient  out  N-bit quotient, final once the iterations have completed
//                  and held until the next start
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int N   = 16,
    parameter int D_W = 12
) (
    input  logic           clk_div,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [N-1:0]   quotient
);

    localparam int CNT_W = $clog2(N + 1);

    logic [D_W-1:0]   rem_q;
    logic [N-1:0]     quo_q;
    logic [D_W-1:0]   div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [D_W:0]     rem_shift;
    logic [D_W:0]     rem_sub;
    logic             fits;
    logic [D_W-1:0]   rem_d;

    // The quotient register doubles as the dividend shift register: its MSB
    // is shifted into the partial remainder while the new quotient bit
    // enters at the LSB.
    always_comb begin
        rem_shift = {rem_q, quo_q[N-1]};
        rem_sub   = rem_shift - {1'b0, div_q};
        fits      = (rem_shift >= {1'b0, div_q});
        // The kept remainder is always below the divisor, so it fits in D_W
        // bits. With divisor 0 every step "fits"; truncation is harmless
        // because only the all-ones quotient matters in that case.
        rem_d     = fits ? rem_sub[D_W-1:0] : rem_shift[D_W-1:0];
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            div_q <= divisor;
            cnt_q <= CNT_W'(N);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[N-2:0], fits};
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = quo_q;

endmodule

// File: rtl/rr_analyzer.sv
// -----------------------------------------------------------------------------
// rr_analyzer
// Averages the last DEPTH accepted RR intervals, converts the average to BPM
// with a sequential divider and flags bradycardia, tachycardia and
// beat-to-beat irregularity. Results are registered and announced with a
// one-cycle strobe 19 edges after the edge that sampled the beat.
//
//   clk_div         in   1 kHz clock
//   rst_n           in   asynchronous active-low reset
//   rr_interval_ms  in   RR interval in ms (12'hFFF = saturated/timeout)
//   new_rr_pulse    in   one-cycle strobe qualifying rr_interval_ms
//   avg_rr_ms       out  mean of the last DEPTH accepted RRs
//   bpm             out  floor(60000 / avg_rr_ms), clamped to 255
//   brady / tachy   out  average above BRADY_MS / below TACHY_MS
//   irregular       out  latest beat deviated from the previous average
//   result_valid    out  set once the first average has been produced
//   result_strobe   out  one-cycle pulse when the outputs above update
//   reject_pulse    out  one-cycle pulse when a beat is rejected
//   busy            out  high whenever the control FSM is not idle
// -----------------------------------------------------------------------------
module rr_analyzer
    import hr_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MIN_RR_MS   = MIN_RR_MS_DEF,
    parameter int BRADY_MS    = BRADY_MS_DEF,
    parameter int TACHY_MS    = TACHY_MS_DEF,
    parameter int IRREG_SHIFT = IRREG_SHIFT_DEF
) (
    input  logic             clk_div,
    input  logic             rst_n,
    input  logic [RR_W-1:0]  rr_interval_ms,
    input  logic             new_rr_pulse,
    output logic [RR_W-1:0]  avg_rr_ms,
    output logic [BPM_W-1:0] bpm,
    output logic             brady,
    output logic             tachy,
    output logic             irregular,
    output logic             result_valid,
    output logic             result_strobe,
    output logic             reject_pulse,
    output logic             busy
);

    localparam int LOG2_D = $clog2(DEPTH);
    localparam int PTR_W  = LOG2_D;
    localparam int SUM_W  = RR_W + LOG2_D;
    localparam int FILL_W = $clog2(DEPTH + 1);

    localparam logic [RR_W-1:0] MIN_RR   = RR_W'(MIN_RR_MS);
    localparam logic [RR_W-1:0] BRADY_TH = RR_W'(BRADY_MS);
    localparam logic [RR_W-1:0] TACHY_TH = RR_W'(TACHY_MS);

    rr_state_t state_q, state_d;

    logic [RR_W-1:0]   buf_q [DEPTH];
    logic [RR_W-1:0]   rr_q;          // beat being processed
    logic [RR_W-1:0]   old_q;         // buffer entry it will overwrite
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [FILL_W-1:0] fill_q;
    logic [SUM_W-1:0]  sum_q;
    logic [RR_W-1:0]   avg_next_q;

    logic [RR_W-1:0]   avg_rr_q;
    logic [BPM_W-1:0]  bpm_q;
    logic              brady_q;
    logic              tachy_q;
    logic              irregular_q;
    logic              result_valid_q;
    logic              result_strobe_q;
    logic              reject_q;

    logic              rr_ok;
    logic              accept;
    logic              reject;
    logic              fills_up;
    logic [RR_W-1:0]   avg_calc;
    logic              div_start;
    logic              div_done;
    logic [15:0]       div_quotient;

    assign rr_ok    = (rr_interval_ms >= MIN_RR) && (rr_interval_ms != RR_SAT);
    // Only IDLE listens; pulses arriving while busy are dropped.
    assign accept   = (state_q == IDLE) && new_rr_pulse && rr_ok;
    assign reject   = (state_q == IDLE) && new_rr_pulse && !rr_ok;
    // True when the ACCUM write brings the buffer to (or keeps it at) full.
    assign fills_up = (fill_q >= FILL_W'(DEPTH - 1));
    // Power-of-two depth: the mean is the sum with its low bits dropped.
    assign avg_calc = sum_q[SUM_W-1:LOG2_D];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                state_d = fills_up ? LOAD : IDLE;
            end
            LOAD: begin
                div_start = 1'b1;
                state_d   = DIVIDE;
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------- RR ring buffer
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            rr_q     <= '0;
            old_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
        end else begin
            if (accept) begin
                rr_q  <= rr_interval_ms;
                // Registered read of the slot about to be replaced, so the
                // running sum can drop it on the next edge.
                old_q <= buf_q[wr_ptr_q];
            end
            if (state_q == ACCUM) begin
                buf_q[wr_ptr_q] <= rr_q;
                sum_q           <= sum_q - SUM_W'(old_q) + SUM_W'(rr_q);
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                if (fill_q != FILL_W'(DEPTH)) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------ divider
    seq_divider #(
        .N   (16),
        .D_W (RR_W)
    ) u_div (
        .clk_div  (clk_div),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (MS_PER_MIN),
        .divisor  (avg_calc),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // ---------------------------------------------------- result registers
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            avg_next_q      <= '0;
            avg_rr_q        <= '0;
            bpm_q           <= '0;
            brady_q         <= 1'b0;
            tachy_q         <= 1'b0;
            irregular_q     <= 1'b0;
            result_valid_q  <= 1'b0;
            result_strobe_q <= 1'b0;
            reject_q        <= 1'b0;
        end else begin
            result_strobe_q <= 1'b0;
            reject_q        <= reject;
            if (state_q == LOAD) begin
                avg_next_q <= avg_calc;
            end
            if (state_q == UPDATE) begin
                avg_rr_q    <= avg_next_q;
                bpm_q       <= clamp_bpm(div_quotient);
                brady_q     <= (avg_next_q > BRADY_TH);
                tachy_q     <= (avg_next_q < TACHY_TH);
                // Compared against the average published before this update;
                // the very first average has nothing to compare with.
                irregular_q <= result_valid_q &&
                               (abs_diff(rr_q, avg_rr_q) > (avg_rr_q >> IRREG_SHIFT));
                result_valid_q  <= 1'b1;
                result_strobe_q <= 1'b1;
            end
        end
    end

    assign avg_rr_ms     = avg_rr_q;
    assign bpm           = bpm_q;
    assign brady         = brady_q;
    assign tachy         = tachy_q;
    assign irregular     = irregular_q;
    assign result_valid  = result_valid_q;
    assign result_strobe = result_strobe_q;
    assign reject_pulse  = reject_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rr_analyzer.sv
// -----------------------------------------------------------------------------
// tb_rr_analyzer
// Table-driven directed vectors, hand-written corner sequences (pulse while
// busy, reset mid-divide) and randomized beats checked against a queue-based
// reference model of the averaging/classification rules.
// -----------------------------------------------------------------------------
module tb_rr_analyzer;

    logic        clk_div = 1'b0;
    logic        rst_n;
    logic [11:0] rr_interval_ms;
    logic        new_rr_pulse;
    logic [11:0] avg_rr_ms;
    logic [7:0]  bpm;
    logic        brady, tachy, irregular;
    logic        result_valid, result_strobe, reject_pulse, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_div = ~clk_div;

    rr_analyzer dut (
        .clk_div        (clk_div),
        .rst_n          (rst_n),
        .rr_interval_ms (rr_interval_ms),
        .new_rr_pulse   (new_rr_pulse),
        .avg_rr_ms      (avg_rr_ms),
        .bpm            (bpm),
        .brady          (brady),
        .tachy          (tachy),
        .irregular      (irregular),
        .result_valid   (result_valid),
        .result_strobe  (result_strobe),
        .reject_pulse   (reject_pulse),
        .busy           (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------ reference model
    int mq[$];
    int m_avg, m_bpm;
    bit m_br, m_ta, m_ir, m_va;

    task automatic model_reset();
        mq.delete();
        m_avg = 0; m_bpm = 0; m_br = 0; m_ta = 0; m_ir = 0; m_va = 0;
    endtask

    task automatic model_beat(input int rr, output bit rej, output bit strb);
        int sum, avg, dev;
        rej  = (rr < 250) || (rr == 4095);
        strb = 0;
        if (!rej) begin
            mq.push_back(rr);
            if (mq.size() > 4) void'(mq.pop_front());
            if (mq.size() == 4) begin
                sum = 0;
                foreach (mq[i]) sum += mq[i];
                avg  = sum / 4;
                dev  = (rr > m_avg) ? rr - m_avg : m_avg - rr;
                m_ir = m_va && (dev > m_avg / 8);
                m_avg = avg;
                m_bpm = (60000 / avg > 255) ? 255 : 60000 / avg;
                m_br  = avg > 1200;
                m_ta  = avg < 500;
                m_va  = 1;
                strb  = 1;
            end
        end
    endtask

    // ------------------------------------------------ beat driver
    // Presents one beat, then watches 30 edges. Optionally injects a second
    // pulse that reaches the DUT on edge 5 (mid-divide).
    task automatic run_beat(input int rr, input bit inject, input int inj_rr,
                            output bit rej, output bit bsy,
                            output int lat, output int nst);
        @(negedge clk_div);
        rr_interval_ms = 12'(rr);
        new_rr_pulse   = 1'b1;
        @(posedge clk_div); #1;
        rej = reject_pulse;
        bsy = busy;
        new_rr_pulse   = 1'b0;
        rr_interval_ms = '0;
        lat = -1;
        nst = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_div); #1;
            if (result_strobe) begin
                nst++;
                if (lat < 0) lat = k;
            end
            if (inject && k == 4) begin
                rr_interval_ms = 12'(inj_rr);
                new_rr_pulse   = 1'b1;
            end
            if (k == 5) begin
                rr_interval_ms = '0;
                new_rr_pulse   = 1'b0;
            end
        end
    endtask

    task automatic check_beat(input string tag, input bit e_rej, input bit e_strb,
                              input int e_avg, input int e_bpm, input bit e_br,
                              input bit e_ta, input bit e_ir, input bit e_va,
                              input bit rej, input bit bsy, input int lat, input int nst);
        chk({tag, " reject"},  rej, e_rej);
        chk({tag, " busy"},    bsy, !e_rej);
        chk({tag, " strobes"}, nst, e_strb);
        if (e_strb) chk({tag, " latency"}, lat, 19);
        chk({tag, " avg"},     avg_rr_ms, e_avg);
        chk({tag, " bpm"},     bpm, e_bpm);
        chk({tag, " brady"},   brady, e_br);
        chk({tag, " tachy"},   tachy, e_ta);
        chk({tag, " irreg"},   irregular, e_ir);
        chk({tag, " valid"},   result_valid, e_va);
        $display("beat %s rr_result avg=%0d bpm=%0d br=%0d ta=%0d ir=%0d va=%0d lat=%0d",
                 tag, avg_rr_ms, bpm, brady, tachy, irregular, result_valid, lat);
    endtask

    // Model-driven beat.
    task automatic do_beat(input string tag, input int rr, input bit inject, input int inj_rr);
        bit rej, bsy, mrej, mstrb;
        int lat, nst;
        run_beat(rr, inject, inj_rr, rej, bsy, lat, nst);
        model_beat(rr, mrej, mstrb);
        check_beat(tag, mrej, mstrb, m_avg, m_bpm, m_br, m_ta, m_ir, m_va,
                   rej, bsy, lat, nst);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " avg"},    avg_rr_ms, 0);
        chk({tag, " bpm"},    bpm, 0);
        chk({tag, " brady"},  brady, 0);
        chk({tag, " tachy"},  tachy, 0);
        chk({tag, " irreg"},  irregular, 0);
        chk({tag, " valid"},  result_valid, 0);
        chk({tag, " strobe"}, result_strobe, 0);
        chk({tag, " reject"}, reject_pulse, 0);
        chk({tag, " busy"},   busy, 0);
    endtask

    // ------------------------------------------------ directed table
    typedef struct {
        int rr;
        bit rej;
        bit strb;
        int avg;
        int bpm;
        bit br, ta, ir, va;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rr, bit rej, bit strb, int avg, int b,
                                bit br, bit ta, bit ir, bit va);
        vec_t v;
        v.rr = rr; v.rej = rej; v.strb = strb; v.avg = avg; v.bpm = b;
        v.br = br; v.ta = ta; v.ir = ir; v.va = va;
        return v;
    endfunction

    initial begin
        bit rej, bsy, mrej, mstrb;
        int lat, nst;

        // Steady 1000 ms: strobe only once the buffer is full.
        tbl.push_back(mk(1000, 0, 0,    0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1000, 0, 0,    0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1000, 0, 0,    0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1000, 0, 1, 1000,  60, 0, 0, 0, 1));
        // Move to 400 ms (tachy).
        tbl.push_back(mk( 400, 0, 1,  850,  70, 0, 0, 1, 1));
        tbl.push_back(mk( 400, 0, 1,  700,  85, 0, 0, 1, 1));
        tbl.push_back(mk( 400, 0, 1,  550, 109, 0, 0, 1, 1));
        tbl.push_back(mk( 400, 0, 1,  400, 150, 0, 1, 1, 1));
        // Move to 1500 ms (brady).
        tbl.push_back(mk(1500, 0, 1,  675,  88, 0, 0, 1, 1));
        tbl.push_back(mk(1500, 0, 1,  950,  63, 0, 0, 1, 1));
        tbl.push_back(mk(1500, 0, 1, 1225,  48, 1, 0, 1, 1));
        tbl.push_back(mk(1500, 0, 1, 1500,  40, 1, 0, 1, 1));
        // Settle at 800 ms.
        tbl.push_back(mk( 800, 0, 1, 1325,  45, 1, 0, 1, 1));
        tbl.push_back(mk( 800, 0, 1, 1150,  52, 0, 0, 1, 1));
        tbl.push_back(mk( 800, 0, 1,  975,  61, 0, 0, 1, 1));
        tbl.push_back(mk( 800, 0, 1,  800,  75, 0, 0, 1, 1));
        // Artefact and timeout are rejected; outputs and buffer unchanged.
        tbl.push_back(mk( 100, 1, 0,  800,  75, 0, 0, 1, 1));
        tbl.push_back(mk(4095, 1, 0,  800,  75, 0, 0, 1, 1));
        tbl.push_back(mk( 800, 0, 1,  800,  75, 0, 0, 0, 1));
        // Irregular beat, then back on average.
        tbl.push_back(mk(1000, 0, 1,  850,  70, 0, 0, 1, 1));
        tbl.push_back(mk( 850, 0, 1,  862,  69, 0, 0, 0, 1));
        // MIN_RR boundary: 249 rejected, 250 accepted.
        tbl.push_back(mk( 249, 1, 0,  862,  69, 0, 0, 0, 1));
        tbl.push_back(mk( 250, 0, 1,  725,  82, 0, 0, 1, 1));

        rst_n          = 1'b0;
        rr_interval_ms = '0;
        new_rr_pulse   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_div);
        #1;
        check_zero("reset");
        @(negedge clk_div);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_beat(tbl[i].rr, 0, 0, rej, bsy, lat, nst);
            model_beat(tbl[i].rr, mrej, mstrb);
            check_beat($sformatf("tbl%0d", i), tbl[i].rej, tbl[i].strb, tbl[i].avg,
                       tbl[i].bpm, tbl[i].br, tbl[i].ta, tbl[i].ir, tbl[i].va,
                       rej, bsy, lat, nst);
        end

        // Second pulse while busy: ignored, values reflect the first beat.
        do_beat("busy_drop", 900, 1, 300);
        // Following beat confirms 300 never entered the buffer.
        do_beat("after_drop", 900, 0, 0);

        // Reset during DIVIDE: immediate clear, no strobe afterwards.
        @(negedge clk_div);
        rr_interval_ms = 12'd1000;
        new_rr_pulse   = 1'b1;
        @(posedge clk_div); #1;
        new_rr_pulse   = 1'b0;
        rr_interval_ms = '0;
        repeat (8) @(posedge clk_div);
        #3;
        chk("pre_reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_div_reset");
        repeat (2) @(negedge clk_div);
        rst_n = 1'b1;
        nst = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk_div); #1;
            if (result_strobe) nst++;
        end
        chk("post_reset strobes", nst, 0);
        model_reset();
        for (int i = 0; i < 4; i++) do_beat($sformatf("fresh%0d", i), 1000, 0, 0);

        // Randomized beats against the model.
        for (int i = 0; i < 40; i++) begin
            int sel, rr;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      rr = int'($urandom_range(0, 249));
            else if (sel == 1) rr = 4095;
            else if (sel == 2) rr = 4094;
            else               rr = int'($urandom_range(250, 2000));
            do_beat($sformatf("rnd%0d", i), rr, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_analyzer.md
Name: rr_analyzer

Overview:
- Downstream consumer of the RR interval detector. Runs on the same 1 kHz clk_div domain.
- Each accepted rr_interval_ms / new_rr_pulse pair goes into a DEPTH-entry circular buffer, which keeps a running sum and average.
- It computes BPM = 60000 / avg_rr with a sequential divider.
- It classifies bradycardia, tachycardia and beat-to-beat irregularity, then presents registered results with a one-cycle strobe.

Parameters:
- DEPTH, 4: RR intervals averaged. Power of two, 2..16.
- MIN_RR_MS, 250: RR below this is an artefact and is rejected (>240 BPM).
- BRADY_MS, 1200: avg_rr above this sets brady (<50 BPM).
- TACHY_MS, 500: avg_rr below this sets tachy (>120 BPM).
- IRREG_SHIFT, 3: irregular if |rr - prev_avg| > prev_avg >> IRREG_SHIFT (12.5%).

Ports:
- clk_div  in  1  1 kHz clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- rr_interval_ms  in  12  RR interval in ms; 12'hFFF means saturated/timeout.
- new_rr_pulse  in  1  one-cycle strobe; rr_interval_ms is valid in the same cycle.
- avg_rr_ms  out  12  mean of the last DEPTH accepted RRs.
- bpm  out  8  floor(60000/avg_rr_ms), clamped to 255.
- brady  out  1  avg_rr_ms > BRADY_MS.
- tachy  out  1  avg_rr_ms < TACHY_MS.
- irregular  out  1  most recent beat deviated from the previous average.
- result_valid  out  1  high once the first average has been produced.
- result_strobe  out  1  one-cycle pulse when the outputs above update.
- reject_pulse  out  1  one-cycle pulse when an RR is rejected.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, immediate): all outputs 0; buffer, sum, fill count, write pointer and FSM (IDLE) cleared. A reset mid-divide abandons the computation and produces no strobe.
- FSM states: IDLE, ACCUM, LOAD, DIVIDE, UPDATE.
- Edge E0 (IDLE, new_rr_pulse=1):
  - If rr < MIN_RR_MS or rr == 12'hFFF: reject_pulse high for the cycle after E0; state unchanged; no other effect.
  - Otherwise: latch rr, go to ACCUM.
- E1 (ACCUM):
  - sum <= sum - buf[wr_ptr] + rr; buf[wr_ptr] <= rr; wr_ptr wraps modulo DEPTH.
  - fill saturates at DEPTH.
  - Sum width is 12 + log2(DEPTH); it never overflows.
  - If fill (after update) < DEPTH: go to IDLE, no strobe. Else go to LOAD.
- E2 (LOAD):
  - avg_next = sum >> log2(DEPTH), truncated.
  - Start the divider: dividend 60000 (16 bit), divisor avg_next.
- E3..E18 (DIVIDE): restoring division, one quotient bit per edge, 16 iterations.
- E19 (UPDATE):
  - Register the outputs. Quotient > 255 clamps to 255.
  - brady/tachy evaluated on avg_next.
  - irregular evaluated against the avg_rr_ms value before this update. If result_valid was 0, irregular=0.
  - result_valid <= 1; go to IDLE.
  - result_strobe is high for exactly the cycle after E19, so fixed latency is 19 edges from the sampling edge.
- new_rr_pulse while busy=1 is dropped silently. This is unreachable in operation because beats are at least MIN_RR_MS apart.
- Divide by zero is unreachable because avg >= MIN_RR_MS. The divider still must not hang on divisor 0: it returns all-ones, clamped to 255.
- Outputs hold their values between strobes. Rejected beats never disturb buffer, sum or fill.

Decomposition:
- Shared package hr_pkg:
  - RR_W=12, BPM_W=8, MS_PER_MIN=16'd60000, RR_SAT=12'hFFF.
  - rr_state_t enum: IDLE, ACCUM, LOAD, DIVIDE, UPDATE.
  - Classification thresholds, so upstream and top-level use the same values.
- One sub-module: seq_divider.
  - Restoring, N=16 dividend / 12-bit divisor.
  - Ports: start, done, quotient.
  - Fixed 16-cycle latency.
  - Owned by rr_analyzer.

Test Plan:
1. Reset, four RRs of 1000 spaced 1000 cycles apart -> no strobe for beats 1–3. After beat 4, strobe 19 edges later with avg_rr_ms=1000, bpm=60, brady=tachy=irregular=0, result_valid=1.
2. Four RRs of 400 -> avg 400, bpm 150, tachy=1. Then four RRs of 1500 -> avg 1500, bpm 40, brady=1, tachy=0.
3. Steady-state avg 800, then RR 1000 -> |200| > 100 gives irregular=1, avg 850, bpm 70. Next RR 850 -> irregular=0.
4. RR 100, then RR 4095 -> reject_pulse each time, no result_strobe, busy stays 0. The next RR 800 from the avg-800 state gives avg 800, so the buffer was unchanged.
5. Second new_rr_pulse injected while busy=1 -> ignored. Exactly one strobe occurs, and its values reflect the first RR only.
6. rst_n low during DIVIDE -> all outputs 0 asynchronously, no strobe. After release, four fresh beats are needed before the next strobe.
